// File: rtl/timer_sequencer.sv
// Bus master that runs one interval measurement on the memory-mapped timer:
// clear/start, wait for stop or MAX_RUN, stop, then read the four count bytes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Write
`define Write 1'b0
`endif

module timer_sequencer #(
  parameter int unsigned BASE    = 0,
  parameter int unsigned MAX_RUN = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_start,
  input  logic                       cmd_stop,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [31:0]                result,
  output logic [`MEM_ADDR_WIDTH-1:0] addr,
  output logic [`DATA_WIDTH-1:0]     wdata,
  input  logic [`DATA_WIDTH-1:0]     rdata,
  output logic                       cs_,
  output logic                       rw_
);
  localparam int AW = `MEM_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam logic [AW-1:0] CNT_ADDR  = AW'(BASE);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(BASE + 4);
  localparam logic [15:0]   RUN_LAST  = 16'(MAX_RUN - 1);
  localparam bit            AUTO_STOP = (MAX_RUN != 0);

  typedef enum logic [3:0] {
    IDLE, CLEAR, START, RUN, STOP, RD0, RD1, RD2, RD3, DONE
  } state_t;

  state_t      state;
  logic [15:0] run_cnt;
  logic        expire;

  assign expire = AUTO_STOP && (run_cnt == RUN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      result  <= '0;
      run_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (cmd_start) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          timeout <= 1'b0;
        end
        CLEAR: state <= START;
        START: begin
          state   <= RUN;
          run_cnt <= '0;
        end
        RUN: begin
          run_cnt <= run_cnt + 16'd1;
          if (cmd_stop || expire) state <= STOP;
          if (expire) timeout <= 1'b1;
        end
        STOP: state <= RD0;
        RD0: begin
          result[7:0] <= rdata;
          state       <= RD1;
        end
        RD1: begin
          result[15:8] <= rdata;
          state        <= RD2;
        end
        RD2: begin
          result[23:16] <= rdata;
          state         <= RD3;
        end
        RD3: begin
          result[31:24] <= rdata;
          state         <= DONE;
          busy          <= 1'b0;
          done          <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from state so each access lines up with its state cycle.
  always_comb begin
    cs_   = ~`Enable_;
    rw_   = ~`Write;
    addr  = '0;
    wdata = '0;
    unique case (state)
      CLEAR: begin cs_ = `Enable_; rw_ = `Write; addr = CTRL_ADDR; wdata = DW'(1); end
      START: begin cs_ = `Enable_; rw_ = `Write; addr = CTRL_ADDR; wdata = DW'(2); end
      STOP:  begin cs_ = `Enable_; rw_ = `Write; addr = CTRL_ADDR; wdata = DW'(4); end
      RD0:   begin cs_ = `Enable_; addr = CNT_ADDR; end
      RD1:   begin cs_ = `Enable_; addr = CNT_ADDR + AW'(1); end
      RD2:   begin cs_ = `Enable_; addr = CNT_ADDR + AW'(2); end
      RD3:   begin cs_ = `Enable_; addr = CNT_ADDR + AW'(3); end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: two instances (MAX_RUN=0 and 5), each on its own timer model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Write
`define Write 1'b0
`endif

module tb_timer_sequencer;
  localparam int unsigned BASE = 32'h20;
  localparam logic [7:0]  CTRL = 8'h24;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       cmd_start, cmd_stop, busy, done, timeout, cs_, rw_;
  logic [1:0][31:0] result;
  logic [1:0][7:0]  addr, wdata, rdata;
  logic [1:0][31:0] tcount;
  logic [1:0]       ten;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  timer_sequencer #(.BASE(BASE), .MAX_RUN(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start[0]), .cmd_stop(cmd_stop[0]),
    .busy(busy[0]), .done(done[0]), .timeout(timeout[0]), .result(result[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .cs_(cs_[0]), .rw_(rw_[0]));

  timer_sequencer #(.BASE(BASE), .MAX_RUN(5)) dut1 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start[1]), .cmd_stop(cmd_stop[1]),
    .busy(busy[1]), .done(done[1]), .timeout(timeout[1]), .result(result[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .cs_(cs_[1]), .rw_(rw_[1]));

  // Timer peripheral: ctrl bit0 clears the count, bit1 is the enable; no reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_[i] == `Enable_ && rw_[i] == `Write && addr[i] == CTRL) begin
        ten[i] <= wdata[i][1];
        if (wdata[i][0]) tcount[i] <= 32'd0;
        else if (ten[i] === 1'b1) tcount[i] <= tcount[i] + 32'd1;
      end else if (ten[i] === 1'b1) begin
        tcount[i] <= tcount[i] + 32'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 2; i++) rdata[i] = 8'(tcount[i] >> {addr[i][1:0], 3'b000});
  end

  // One measurement starting at the current negedge (cycle 0).  Reference:
  // stop sampled in RUN cycle k gives result k-1; auto-stop acts as stop at k=MAX_RUN+2.
  task automatic measure(input int d, input int stop_at, input int ign_stop,
                         input int ign_a, input int ign_b, input string name);
    int mr, k;
    bit to_exp, e_act, e_wr;
    logic [7:0] e_addr, e_wdata;
    logic [19:0] obs, exp;
    logic act, wr;
    mr = (d == 1) ? 5 : 0;
    if (stop_at >= 3 && (mr == 0 || stop_at < mr + 2)) begin k = stop_at; to_exp = 1'b0; end
    else begin k = mr + 2; to_exp = 1'b1; end
    for (int c = 0; c <= k + 7; c++) begin
      if (c > 0) @(negedge clk);
      cmd_start[d] = (c == 0 || c == ign_a || c == ign_b);
      cmd_stop[d]  = (c == stop_at || c == ign_stop);
      e_act = 1'b0; e_wr = 1'b0; e_addr = 8'h0; e_wdata = 8'h0;
      if (c == 1 || c == 2 || c == k + 1) begin
        e_act = 1'b1; e_wr = 1'b1; e_addr = CTRL;
        e_wdata = (c == 1) ? 8'd1 : (c == 2) ? 8'd2 : 8'd4;
      end else if (c >= k + 2 && c <= k + 5) begin
        e_act = 1'b1; e_addr = 8'(BASE + c - k - 2);
      end
      exp = {(c >= 1 && c <= k + 5), (c == k + 6), e_act ? `Enable_ : ~`Enable_,
             e_act ? (e_wr ? `Write : ~`Write) : 1'b0, e_addr, e_wdata};
      act = (cs_[d] == `Enable_);
      wr  = act && (rw_[d] == `Write);
      obs = {busy[d], done[d], cs_[d], act ? rw_[d] : 1'b0,
             act ? addr[d] : 8'h0, wr ? wdata[d] : 8'h0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s dut%0d cycle %0d bus/status: got %h want %h", name, d, c, obs, exp);
      end
    end
    vectors++;
    if ({timeout[d], result[d]} !== {to_exp, 32'(k - 1)}) begin
      miscompares++;
      $display("FAIL %s dut%0d result/timeout: got %0d/%0b want %0d/%0b",
               name, d, result[d], timeout[d], k - 1, to_exp);
    end
  endtask

  task automatic test_reset();
    logic [34:0] want;
    rst = 1'b1; cmd_start = '0; cmd_stop = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    want = {1'b0, 1'b0, ~`Enable_, 1'b0, 32'd0};
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({busy[d], done[d], cs_[d], timeout[d], result[d]} !== want) begin
          miscompares++;
          $display("FAIL reset_idle dut%0d cycle %0d: got %h want %h", d, c,
                   {busy[d], done[d], cs_[d], timeout[d], result[d]}, want);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    measure(0, 10, -1, -1, -1, "basic_stop10");
  endtask

  task automatic test_auto_stop();
    measure(1, -1, -1, -1, -1, "auto_stop");
  endtask

  task automatic test_ignored_start();
    measure(0, 10, -1, 5, 13, "start_while_busy");
  endtask

  task automatic test_stop_at_expiry();
    measure(1, 7, 0, -1, -1, "stop_at_expiry");
  endtask

  // Reset lands in RUN; the timer keeps its enable, so the next run proves the clear.
  task automatic test_reset_mid();
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      cmd_start[1] = (c == 0);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy[1], cs_[1], timeout[1], result[1]} !== {1'b0, ~`Enable_, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_mid async: got busy %b cs_ %b to %b result %0d want 0 %b 0 0",
               busy[1], cs_[1], timeout[1], result[1], ~`Enable_);
    end
    @(negedge clk);
    rst = 1'b0;
    measure(1, 4, -1, -1, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      int d, s, kk;
      d  = $urandom_range(0, 1);
      s  = (d == 1) ? $urandom_range(3, 10) : $urandom_range(3, 40);
      kk = (d == 1 && s > 7) ? 7 : s;
      measure(d, s, $urandom_range(0, 2), $urandom_range(1, kk),
              $urandom_range(kk + 1, kk + 5), "random");
    end
  endtask

  task automatic test_long();
    measure(0, 70000, -1, -1, -1, "long_run");
    vectors++;
    if (result[0][23:16] !== 8'h01) begin
      miscompares++;
      $display("FAIL long_run byte2: got %h want 01", result[0][23:16]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto_stop();
    test_ignored_start();
    test_stop_at_expiry();
    test_reset_mid();
    test_back_to_back();
    test_long();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
